// File: rtl/mmu_pkg.sv
// Shared MMU types and constants used by the TLBs and the page table walker arbiter.
package mmu_pkg;

    localparam int PAGE_OFFSET_W = 12;
    localparam int PTE_W         = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ptw_arbiter_rr_pick.sv
// Rotating-priority picker: the first set bit of pend_valid found when scanning
// from rr_ptr upward, wrapping at NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pend_valid,
    input  logic [IW-1:0]      rr_ptr,
    output logic               any,
    output logic [IW-1:0]      idx
);

    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (!any && pend_valid[j]) begin
                any = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/ptw_arbiter.sv
// Shares one page table walker among NUM_REQ TLBs: per-requester pending slots,
// round-robin grant, one walk in flight, timeout with drain of the late reply.
module ptw_arbiter
    import mmu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int VADDR_W = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*VADDR_W-1:0] req_vaddr_i,
    output logic [NUM_REQ-1:0]         resp_valid_o,
    output logic [PTE_W-1:0]           resp_pte_o,
    output logic                       resp_fault_o,
    output logic                       ptw_req_o,
    output logic [VADDR_W-1:0]         ptw_vaddr_o,
    input  logic                       ptw_resp_valid_i,
    input  logic [PTE_W-1:0]           ptw_pte_i,
    input  logic                       ptw_fault_i,
    output logic                       busy_o,
    output logic                       overflow_o
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_t                        state;
    logic [NUM_REQ-1:0]                pend_valid;
    logic [NUM_REQ-1:0][VADDR_W-1:0]   pend_vaddr;
    logic [IW-1:0]                     rr_ptr, grant, pick_idx, grant_nxt;
    logic [TO_W-1:0]                   to_cnt;
    logic                              pick_any, done_resp, done_to;
    logic [NUM_REQ-1:0]                clr, free;

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .pend_valid (pend_valid),
        .rr_ptr     (rr_ptr),
        .any        (pick_any),
        .idx        (pick_idx)
    );

    assign done_resp = (state == WAIT) && ptw_resp_valid_i;
    assign done_to   = (state == WAIT) && !ptw_resp_valid_i && (to_cnt == TO_W'(TIMEOUT - 1));
    assign grant_nxt = (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    assign busy_o    = (state != IDLE);

    // A slot being released this cycle counts as free, so a new miss is kept.
    always_comb begin
        clr  = '0;
        free = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            clr[i]  = (done_resp || done_to) && (grant == IW'(i));
            free[i] = !pend_valid[i] || clr[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_valid <= '0;
            pend_vaddr <= '0;
            overflow_o <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid_i[i] && free[i]) begin
                    pend_valid[i] <= 1'b1;
                    pend_vaddr[i] <= req_vaddr_i[i*VADDR_W +: VADDR_W];
                end else if (clr[i]) begin
                    pend_valid[i] <= 1'b0;
                end
            end
            if (|(req_valid_i & ~free))
                overflow_o <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant        <= '0;
            to_cnt       <= '0;
            ptw_req_o    <= 1'b0;
            ptw_vaddr_o  <= '0;
            resp_valid_o <= '0;
            resp_pte_o   <= '0;
            resp_fault_o <= 1'b0;
        end else begin
            ptw_req_o    <= 1'b0;
            resp_valid_o <= '0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant       <= pick_idx;
                        ptw_vaddr_o <= pend_vaddr[pick_idx];
                        ptw_req_o   <= 1'b1;
                        to_cnt      <= '0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (ptw_resp_valid_i) begin
                        resp_valid_o[grant] <= 1'b1;
                        resp_pte_o          <= ptw_pte_i;
                        resp_fault_o        <= ptw_fault_i;
                        rr_ptr              <= grant_nxt;
                        state               <= IDLE;
                    end else if (done_to) begin
                        resp_valid_o[grant] <= 1'b1;
                        resp_pte_o          <= '0;
                        resp_fault_o        <= 1'b1;
                        rr_ptr              <= grant_nxt;
                        state               <= DRAIN;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                // The walker still owes a reply for the abandoned walk; swallow it.
                DRAIN: begin
                    if (ptw_resp_valid_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ptw_arbiter.md
Name: ptw_arbiter

Overview:
Shares one page table walker (PTW) between NUM_REQ TLBs, for example the instruction TLB and the data TLB. It captures each TLB's one-cycle miss pulse into a per-requester pending slot and grants the walker round-robin, one walk at a time. It routes the walker's PTE or fault back to the requester that was granted. A walk timeout returns a fault, and the late walker response is then drained and dropped.

Parameters:
NUM_REQ, 2, number of TLB requesters (2 to 4)
VADDR_W, 32, virtual address width
TIMEOUT, 255, WAIT cycles before timeout fault (1 to 2^TO_W-1)
TO_W, 8, timeout counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset; one clock; synchronous, active-low
req_valid_i  in  NUM_REQ  per-TLB miss pulse (TLB ptw_req_o)
req_vaddr_i  in  NUM_REQ*VADDR_W  per-TLB vaddr; slice i = [i*VADDR_W +: VADDR_W]
resp_valid_o  out  NUM_REQ  one-hot response pulse to requester i
resp_pte_o  out  32  PTE returned; shared by all requesters, qualified by resp_valid_o
resp_fault_o  out  1  fault; qualified by resp_valid_o
ptw_req_o  out  1  one-cycle walk request
ptw_vaddr_o  out  VADDR_W  walk address; held stable from ptw_req_o until the walk completes
ptw_resp_valid_i  in  1  walker response
ptw_pte_i  in  32  walker PTE
ptw_fault_i  in  1  walker fault
busy_o  out  1  high in WAIT or DRAIN
overflow_o  out  1  sticky; a pulse arrived while that requester's slot was full

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; pend_valid, pend_vaddr, rr_ptr, grant, to_cnt all 0. Every output is 0, including overflow_o.
- Reset mid-walk: any walker response arriving afterwards lands in IDLE and is ignored.
- Capture:
  - req_valid_i[i]=1 with slot i empty: pend_valid[i]<=1, pend_vaddr[i]<=vaddr slice.
  - Slot i full: the pulse is dropped and overflow_o<=1 (sticky until reset).
  - Capture and clear of the same slot in the same cycle: capture wins.
- Arbitration (IDLE, any pend_valid, registered view):
  - Pick the first pending index scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - grant<=idx, ptw_vaddr_o<=pend_vaddr[idx], ptw_req_o<=1 (exactly one cycle), to_cnt<=0, go to WAIT.
  - A TLB pulse at edge t gives ptw_req_o high in cycle t+2.
- WAIT:
  - ptw_req_o<=0; to_cnt increments each cycle.
  - On ptw_resp_valid_i: resp_valid_o[grant]<=1 for one cycle, resp_pte_o<=ptw_pte_i, resp_fault_o<=ptw_fault_i. Then pend_valid[grant]<=0, rr_ptr<=(grant+1) mod NUM_REQ, go to IDLE.
  - Response latency to the TLB is 1 cycle after ptw_resp_valid_i.
  - Else if to_cnt==TIMEOUT-1: fault response to grant (resp_pte_o<=0, resp_fault_o<=1), clear the slot, advance rr_ptr, go to DRAIN.
  - Response and timeout in the same cycle: the response wins.
- DRAIN: no new ptw_req_o. Wait for ptw_resp_valid_i, discard it without forwarding, go to IDLE. Pending slots keep capturing.
- IDLE: ptw_resp_valid_i is ignored. resp_valid_o is 0 in every cycle except response cycles.
- Slots may fill in any state. At most one walk is outstanding, so there is never more than one resp_valid_o bit set.
- rr_ptr has width $clog2(NUM_REQ) and wraps from NUM_REQ-1 to 0.

Decomposition:
- mmu_pkg holds arb_state_t (IDLE, WAIT, DRAIN; 2-bit enum), PAGE_OFFSET_W=12 and PTE_W=32, shared with the tlb.
- One sub-module, rr_pick: combinational rotate-priority picker. Inputs are pend_valid and rr_ptr; outputs are any and idx.

Test Plan:
- Single request: req_valid_i=01, vaddr0=0x12345678; walker returns pte=0xABCDE003 three cycles after the request. Expect ptw_req_o one cycle with vaddr 0x12345678, then resp_valid_o=01, pte 0xABCDE003, fault=0.
- Simultaneous requests: req_valid_i=11 in the same cycle, rr_ptr=0. Expect requester 0 served first, requester 1 second with its own vaddr, and rr_ptr back to 0. Repeat: requester 1 is served first after any lone grant to 0.
- Walker fault: ptw_fault_i=1 with pte 0. Expect resp_fault_o=1 to the granted requester only, and the slot cleared.
- Timeout with TIMEOUT=4: walker silent. Expect a fault response 4 cycles into WAIT and busy_o held in DRAIN. A late walker response at cycle 10 produces no resp_valid_o. A queued requester 1 gets ptw_req_o the cycle after IDLE.
- Overflow: second pulse from requester 0 while its slot is pending. Expect overflow_o=1 sticky, the original vaddr kept, and one response only.
- Reset mid-WAIT: rst_n=0 for one edge. Expect all outputs 0 and slots empty. A walker response after reset produces no resp_valid_o.
